// File: rtl/note_scroller_if.sv
// Signal bundle between a song source and the note_scroller block.
// With NOTE_SCROLLER_PAUSE_EN defined the bundle also carries a pause request.
interface note_scroller_if #(
  parameter int WINDOW = 16
);
  logic                 start;
  logic [99:0]          song_red;
  logic [99:0]          song_blue;
  logic [99:0]          song_yellow;
  logic [7:0]           song_total_notes;
`ifdef NOTE_SCROLLER_PAUSE_EN
  logic                 pause;
`endif

  logic                 busy;
  logic                 done;
  logic                 beat_tick;
  logic                 hit_red;
  logic                 hit_blue;
  logic                 hit_yellow;
  logic [WINDOW-1:0]    win_red;
  logic [WINDOW-1:0]    win_blue;
  logic [WINDOW-1:0]    win_yellow;
  logic [6:0]           beat_index;
  logic [7:0]           notes_remaining;

  modport master (
`ifdef NOTE_SCROLLER_PAUSE_EN
    output pause,
`endif
    output start, song_red, song_blue, song_yellow, song_total_notes,
    input  busy, done, beat_tick, hit_red, hit_blue, hit_yellow,
    input  win_red, win_blue, win_yellow, beat_index, notes_remaining
  );

  modport slave (
`ifdef NOTE_SCROLLER_PAUSE_EN
    input  pause,
`endif
    input  start, song_red, song_blue, song_yellow, song_total_notes,
    output busy, done, beat_tick, hit_red, hit_blue, hit_yellow,
    output win_red, win_blue, win_yellow, beat_index, notes_remaining
  );
endinterface

// File: rtl/note_scroller.sv
// Three-lane note scroller: loads a 100-beat song and shifts it through a hit zone once per beat.
// Optional macro NOTE_SCROLLER_PAUSE_EN adds a pause input that freezes scrolling while in RUN.
module note_scroller #(
  parameter int BEAT_DIV = 12500000,
  parameter int WINDOW   = 16
) (
  input  logic           clk,
  input  logic           resetn,
  note_scroller_if.slave bus
);

  localparam int SONG_LEN = 100;
  localparam int DIV_W    = $clog2(BEAT_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BEAT_DIV - 1);
  localparam logic [6:0]       LAST_BEAT = 7'(SONG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DIV_W-1:0]      div_q;
  logic [SONG_LEN-1:0]   lane_red_q;
  logic [SONG_LEN-1:0]   lane_blue_q;
  logic [SONG_LEN-1:0]   lane_yellow_q;
  logic [6:0]            beat_q;
  logic [7:0]            notes_q;
  logic                  tick_q;

  logic                  load;
  logic                  stall;
  logic                  advance;
  logic                  last_beat;
  logic [1:0]            hit_cnt;
  logic [7:0]            notes_next;

`ifdef NOTE_SCROLLER_PAUSE_EN
  assign stall = bus.pause;
`else
  assign stall = 1'b0;
`endif

  // A load is only honoured outside RUN; a start during RUN is dropped.
  assign load      = (state_q != RUN) && bus.start;
  assign advance   = (state_q == RUN) && !stall && (div_q == DIV_LAST);
  assign last_beat = (beat_q == LAST_BEAT);

  // Notes leaving the hit zone on this advance, then a saturating subtract.
  assign hit_cnt    = {1'b0, lane_red_q[SONG_LEN-1]}
                    + {1'b0, lane_blue_q[SONG_LEN-1]}
                    + {1'b0, lane_yellow_q[SONG_LEN-1]};
  assign notes_next = (notes_q < {6'b0, hit_cnt}) ? 8'd0 : notes_q - {6'b0, hit_cnt};

  // NOTE: always_comb assigns every output a default first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (advance && last_beat) state_d = DONE;
      DONE:    if (bus.start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q   <= '0;
      beat_q  <= '0;
      notes_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= advance;
      if (load) begin
        div_q   <= '0;
        beat_q  <= '0;
        notes_q <= bus.song_total_notes;
      end else if (state_q == RUN && !stall) begin
        div_q <= advance ? '0 : div_q + DIV_W'(1);
        if (advance) begin
          beat_q  <= beat_q + 7'd1;
          notes_q <= notes_next;
        end
      end
    end
  end

  // NOTE: the lane registers are wide but still reset, because the window outputs must read zero in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane_red_q    <= '0;
      lane_blue_q   <= '0;
      lane_yellow_q <= '0;
    end else if (load) begin
      lane_red_q    <= bus.song_red;
      lane_blue_q   <= bus.song_blue;
      lane_yellow_q <= bus.song_yellow;
    end else if (advance) begin
      if (last_beat) begin
        lane_red_q    <= '0;
        lane_blue_q   <= '0;
        lane_yellow_q <= '0;
      end else begin
        lane_red_q    <= {lane_red_q[SONG_LEN-2:0], 1'b0};
        lane_blue_q   <= {lane_blue_q[SONG_LEN-2:0], 1'b0};
        lane_yellow_q <= {lane_yellow_q[SONG_LEN-2:0], 1'b0};
      end
    end
  end

  // Everything visible comes straight off a register.
  assign bus.busy            = (state_q == RUN);
  assign bus.done            = (state_q == DONE);
  assign bus.beat_tick       = tick_q;
  assign bus.hit_red         = lane_red_q[SONG_LEN-1];
  assign bus.hit_blue        = lane_blue_q[SONG_LEN-1];
  assign bus.hit_yellow      = lane_yellow_q[SONG_LEN-1];
  assign bus.win_red         = lane_red_q[SONG_LEN-1 -: WINDOW];
  assign bus.win_blue        = lane_blue_q[SONG_LEN-1 -: WINDOW];
  assign bus.win_yellow      = lane_yellow_q[SONG_LEN-1 -: WINDOW];
  assign bus.beat_index      = beat_q;
  assign bus.notes_remaining = notes_q;

endmodule
